// File: rtl/cnt_capture_pkg.sv
// Shared definitions for the cnt_capture block: FSM encoding, default widths
// and the {epoch, count} layout of the captured time-stamp.
package cnt_capture_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FULL  = 2'd2
    } cap_state_t;

    localparam int CW_DEF = 4;
    localparam int WW_DEF = 8;

    // Count occupies the LSBs; the epoch starts right above it.
    localparam int CAP_CNT_LSB = 0;

    function automatic int cap_epoch_lsb(input int cw);
        return CAP_CNT_LSB + cw;
    endfunction

endpackage

// File: rtl/cnt_change_det.sv
// Registers the previous count and decodes change, wrap and compare-match
// strobes from the current/previous count pair.
module cnt_change_det
    import cnt_capture_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic          ck,
    input  logic          res,
    input  logic [CW-1:0] q,
    input  logic [CW-1:0] cmp,
    output logic          o_change,
    output logic          o_wrap,
    output logic          o_match
);

    logic [CW-1:0] r_q_d;

    always_ff @(posedge ck or posedge res) begin
        if (res) begin
            r_q_d <= '0;
        end else begin
            r_q_d <= q;
        end
    end

    // q_d resets to the same value the counter does, so no strobe fires on the first edge out of reset.
    always_comb begin
        o_change = (q != r_q_d);
        o_wrap   = (r_q_d == {CW{1'b1}}) && (q == '0);
        o_match  = o_change && (q == cmp);
    end

endmodule

// File: rtl/cnt_capture.sv
// Compare-and-capture stage behind the ripple counter, with valid/ack output
// and overrun flag. Optional wrap epoch: define CNT_CAPTURE_WRAP_EN.
module cnt_capture
    import cnt_capture_pkg::*;
#(
    parameter int CW = CW_DEF,
    parameter int WW = WW_DEF
) (
    input  logic             ck,
    input  logic             res,
    input  logic [CW-1:0]    q,
    input  logic [CW-1:0]    cmp,
    input  logic             arm,
    input  logic             cont,
    output logic [WW+CW-1:0] cap_data,
    output logic             cap_valid,
    input  logic             cap_ack,
    output logic             match,
    output logic             overrun,
    output logic [WW-1:0]    wrap_cnt
);

    logic             w_change;
    logic             w_wrap;
    logic             w_hit;
    logic [1:0]       w_unused;
    logic [WW-1:0]    w_epoch_next;
    logic             w_load;
    logic             w_ovr_set;
    logic             w_ovr_clr;
    cap_state_t       r_state;
    cap_state_t       w_state_next;
    logic [WW+CW-1:0] r_cap_data;
    logic             r_match;
    logic             r_overrun;

    cnt_change_det #(.CW(CW)) u_det (
        .ck       (ck),
        .res      (res),
        .q        (q),
        .cmp      (cmp),
        .o_change (w_change),
        .o_wrap   (w_wrap),
        .o_match  (w_hit)
    );

    assign w_unused = {w_change, w_wrap};

`ifdef CNT_CAPTURE_WRAP_EN
    logic [WW-1:0] r_epoch;

    always_ff @(posedge ck or posedge res) begin
        if (res) begin
            r_epoch <= '0;
        end else if (w_wrap) begin
            r_epoch <= r_epoch + WW'(1);
        end
    end

    // A capture on the wrap edge carries the epoch being entered.
    assign w_epoch_next = w_wrap ? (r_epoch + WW'(1)) : r_epoch;
    assign wrap_cnt     = r_epoch;
`else
    assign w_epoch_next = '0;
    assign wrap_cnt     = '0;
`endif

    always_ff @(posedge ck or posedge res) begin
        if (res) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (arm) begin
                    w_state_next = ARMED;
                end
            end
            ARMED: begin
                if (w_hit) begin
                    w_state_next = FULL;
                end
            end
            FULL: begin
                // Continuous mode with a coincident match reloads and stays FULL.
                if (cap_ack) begin
                    if (!cont) begin
                        w_state_next = IDLE;
                    end else if (!w_hit) begin
                        w_state_next = ARMED;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        cap_valid = (r_state == FULL);
        w_load    = ((r_state == ARMED) && w_hit) ||
                    ((r_state == FULL) && cap_ack && cont && w_hit);
        w_ovr_set = (r_state == FULL) && w_hit && !cap_ack;
        w_ovr_clr = arm && ((r_state == ARMED) || (r_state == FULL));
    end

    always_ff @(posedge ck or posedge res) begin
        if (res) begin
            r_cap_data <= '0;
            r_match    <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_match <= w_hit;
            if (w_load) begin
                r_cap_data <= {w_epoch_next, q};
            end
            // A fresh loss outranks a simultaneous clear request.
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (w_ovr_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign cap_data = r_cap_data;
    assign match    = r_match;
    assign overrun  = r_overrun;

endmodule

// File: tb/tb_cnt_capture.sv
// Randomised and directed bench for cnt_capture against a behavioural model.
module tb_cnt_capture;

    localparam int CW = 4;
    localparam int WW = 8;

    logic             ck = 1'b0;
    logic             res = 1'b1;
    logic [CW-1:0]    q = '0;
    logic [CW-1:0]    cmp = '0;
    logic             arm = 1'b0;
    logic             cont = 1'b0;
    logic             cap_ack = 1'b0;
    logic [WW+CW-1:0] cap_data;
    logic             cap_valid;
    logic             match;
    logic             overrun;
    logic [WW-1:0]    wrap_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [CW-1:0] cnt = '0;
    logic          drv_cont = 1'b0;

    // Reference model state
    bit               m_armed;
    bit               m_pend;
    bit               m_ovr;
    bit               m_match;
    int               m_epoch;
    logic [WW+CW-1:0] m_data;
    logic [CW-1:0]    m_prev;

    cnt_capture #(.CW(CW), .WW(WW)) dut (
        .ck        (ck),
        .res       (res),
        .q         (q),
        .cmp       (cmp),
        .arm       (arm),
        .cont      (cont),
        .cap_data  (cap_data),
        .cap_valid (cap_valid),
        .cap_ack   (cap_ack),
        .match     (match),
        .overrun   (overrun),
        .wrap_cnt  (wrap_cnt)
    );

    always #5 ck = ~ck;

    function automatic logic [WW-1:0] epoch_exp(input int e);
`ifdef CNT_CAPTURE_WRAP_EN
        return WW'(e);
`else
        return '0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_armed = 0;
        m_pend  = 0;
        m_ovr   = 0;
        m_match = 0;
        m_epoch = 0;
        m_data  = '0;
        m_prev  = '0;
    endfunction

    task automatic model_step();
        bit chg, wrp, hit, ov_set, ov_clr;
        chg = (q != m_prev);
        wrp = (m_prev == {CW{1'b1}}) && (q == '0);
        hit = chg && (q == cmp);
        if (wrp) m_epoch = (m_epoch + 1) % (1 << WW);
        ov_set = m_pend && hit && !cap_ack;
        ov_clr = arm && (m_armed || m_pend);
        m_match = hit;
        if (m_pend) begin
            if (cap_ack) begin
                if (cont && hit) begin
                    m_data = {epoch_exp(m_epoch), q};
                end else begin
                    m_pend  = 0;
                    m_armed = cont;
                end
            end
        end else if (m_armed) begin
            if (hit) begin
                m_data  = {epoch_exp(m_epoch), q};
                m_pend  = 1;
                m_armed = 0;
            end
        end else if (arm) begin
            m_armed = 1;
        end
        if (ov_set) m_ovr = 1;
        else if (ov_clr) m_ovr = 0;
        m_prev = q;
    endtask

    task automatic check_all();
        chk("cap_valid", cap_valid, m_pend);
        chk("cap_data", cap_data, m_data);
        chk("match", match, m_match);
        chk("overrun", overrun, m_ovr);
        chk("wrap_cnt", wrap_cnt, epoch_exp(m_epoch));
    endtask

    // Entered and left at a falling edge.
    task automatic tick(input logic [CW-1:0] qv, input logic a, input logic k);
        q       = qv;
        arm     = a;
        cont    = drv_cont;
        cap_ack = k;
        @(posedge ck);
        model_step();
        #1;
        check_all();
        @(negedge ck);
    endtask

    task automatic run(input logic a, input logic k);
        tick(cnt, a, k);
        cnt = cnt + 1'b1;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!cap_valid && n < budget) begin
            run(1'b0, 1'b0);
            n++;
        end
        if (!cap_valid) chk(tag, 0, 1);
    endtask

    task automatic do_reset();
        res     = 1'b1;
        q       = '0;
        cnt     = '0;
        cmp     = '0;
        arm     = 1'b0;
        cap_ack = 1'b0;
        model_reset();
        #1;
        chk("rst_valid", cap_valid, 0);
        chk("rst_data", cap_data, 0);
        chk("rst_match", match, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_wrap", wrap_cnt, 0);
        @(posedge ck);
        @(negedge ck);
        res = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CW-1:0] qv;
        int r;
        model_reset();
        @(negedge ck);
        do_reset();

        // Single capture at 5, then overrun and its clear.
        cmp = 4'd5;
        run(1'b1, 1'b0);
        wait_valid("cap5_timeout", 20);
        chk("cap5_data", cap_data, 12'h005);
        chk("cap5_match", match, 1);
        for (int i = 0; i < 20; i++) run(1'b0, 1'b0);
        chk("ovr_set", overrun, 1);
        chk("ovr_hold_data", cap_data, 12'h005);
        run(1'b1, 1'b0);
        chk("ovr_clr", overrun, 0);
        run(1'b0, 1'b1);
        chk("ack_idle", cap_valid, 0);

        // Continuous mode on cmp=0: captures land on the wrap edges.
        do_reset();
        drv_cont = 1'b1;
        run(1'b1, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            wait_valid("cont_timeout", 20);
            chk("cont_data", cap_data, {epoch_exp(k), 4'h0});
            run(1'b0, 1'b0);
            run(1'b0, 1'b0);
            run(1'b0, 1'b1);
            chk("cont_rearm", cap_valid, 0);
        end

        // Single shot: ack coincides with the next match and drops it.
        cmp = 4'd7;
        wait_valid("ss_timeout", 20);
        drv_cont = 1'b0;
        for (int i = 0; i < 16 && cnt != 4'd7; i++) run(1'b0, 1'b0);
        run(1'b0, 1'b1);
        chk("ss_valid", cap_valid, 0);
        chk("ss_overrun", overrun, 0);
        chk("ss_match", match, 1);

        // Reset mid-count at q=9 with a capture pending.
        cmp = 4'd3;
        run(1'b1, 1'b0);
        wait_valid("mid_timeout", 20);
        for (int i = 0; i < 16 && cnt != 4'd9; i++) run(1'b0, 1'b0);
        run(1'b0, 1'b0);
        chk("mid_pending", cap_valid, 1);
        do_reset();
        tick(4'd0, 1'b0, 1'b0);
        chk("post_rst_match", match, 0);

        // cmp=all-ones captures the pre-wrap epoch.
        cmp = 4'hF;
        run(1'b1, 1'b0);
        wait_valid("f_timeout", 20);
        chk("f_data", cap_data, 12'h00F);
        chk("f_wrap0", wrap_cnt, 0);
        run(1'b0, 1'b0);
        chk("f_wrap1", wrap_cnt, epoch_exp(1));

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 199);
            if (r == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 15) == 0) cmp = CW'($urandom);
                drv_cont = 1'($urandom_range(0, 1));
                if (r < 25) begin
                    qv = q;
                end else if (r < 33) begin
                    qv  = CW'($urandom);
                    cnt = qv + 1'b1;
                end else begin
                    qv  = cnt;
                    cnt = cnt + 1'b1;
                end
                tick(qv, $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cnt_capture.md
# cnt_capture

- Sits directly downstream of the 4-bit ripple counter and consumes its `q` bus.
- Watches the count for a programmable compare value and captures a time-stamp (wrap epoch plus count) when a match occurs.
- Presents the time-stamp to the next stage through a valid/ack handshake.
- Tracks counter wrap-around (all-ones to zero) and flags captures lost while a previous one is pending.

## Interface
Parameters:
- `CW`, 4: counter width; must equal the upstream counter width.
- `WW`, 8: wrap-epoch counter width.

Ports:
- `ck` in 1: clock, shared with the upstream counter.
- `res` in 1: reset; asynchronous and active-high, shared with the upstream counter.
- `q` in CW: count value from the upstream counter.
- `cmp` in CW: compare value; sampled every cycle.
- `arm` in 1: one-cycle pulse that enables capture.
- `cont` in 1: 1 = re-arm automatically after ack; 0 = single shot.
- `cap_data` out WW+CW: captured value, laid out as {epoch, count}.
- `cap_valid` out 1: capture pending.
- `cap_ack` in 1: consumer accepts `cap_data`.
- `match` out 1: one-cycle pulse on every qualifying match, whatever the state.
- `overrun` out 1: sticky; a capture was lost.
- `wrap_cnt` out WW: current wrap epoch.

## Operation
- `q_d` is a register holding the previous `q`.
- A change event is `q != q_d`.
- A wrap event is `q_d == all-ones && q == 0`.
- A qualifying match is a change event with `q == cmp`. A static count never re-matches.
- `wrap_cnt` increments on each wrap event, modulo 2^WW.
- State machine:
  - IDLE: on `arm`, go to ARMED. Matches only pulse `match`.
  - ARMED: on a qualifying match, load `cap_data` = {epoch, q} and go to FULL. If a wrap happens on the same edge, the epoch loaded is the post-increment value.
  - FULL: `cap_valid` = 1. On `cap_ack`, go to ARMED if `cont` = 1, otherwise to IDLE. A match without `cap_ack` sets `overrun`; `cap_data` is held.
- `cap_ack` together with a match on the same edge while in FULL:
  - `cont` = 1: the new data is loaded and the block stays in FULL, with no overrun.
  - `cont` = 0: the block goes to IDLE and the match is dropped silently.
- `arm` while in ARMED or FULL: no state change; clears `overrun`.
- `cap_ack` while not in FULL is ignored.

## Timing
- Reset values: `q_d`=0, state=IDLE, `cap_data`=0, `cap_valid`=0, `match`=0, `overrun`=0, `wrap_cnt`=0.
- Latency: a qualifying `q` sampled at edge N gives `match` and `cap_valid` high after edge N. `cap_data` is valid in the same cycle.
- `cap_valid` falls on the edge that samples `cap_ack` = 1, unless the same-edge reload above applies.
- Reset while the counter is running: `q` returns to 0 together with `q_d`. No false wrap or match is generated on the first edge after reset, including when `cmp` = 0.
- `cmp` = all-ones: the match fires on the edge before the wrap and carries the pre-wrap epoch.

## Configuration
- `CNT_CAPTURE_WRAP_EN` defined: the wrap-epoch counter is built, and the `cap_data` MSBs and `wrap_cnt` carry the epoch.
- Not defined:
  - no epoch register;
  - `wrap_cnt` is tied to 0;
  - the `cap_data` epoch field is 0;
  - port widths are unchanged.

## Structure
- Package `cnt_capture_pkg` holds:
  - the state encoding: IDLE=2'd0, ARMED=2'd1, FULL=2'd2;
  - the default `CW` and `WW`;
  - the `cap_data` field offsets.
- Sub-module `cnt_change_det` (inputs `ck`, `res`, `q`, `cmp`):
  - owns `q_d`;
  - produces the change, wrap and qualifying-match strobes combinationally from `q` and `q_d`.

## Test plan
- Reset, then `arm`, `cmp`=5, counter free-running → `match` and `cap_valid` go high one cycle after `q`=5 is sampled; `cap_data`=0x005; no further capture until ack.
- Hold `cap_ack` low for 20 cycles with `cmp`=5 → `overrun`=1 on the next occurrence of 5; `cap_data` stays 0x005; `arm` clears `overrun`.
- `cont`=1, `cmp`=0, ack 3 cycles after each capture → captures 0x010, 0x020, 0x030 with WRAP_EN defined (the post-increment epoch is loaded on the match/wrap edge); 0x000 each time without it.
- `cont`=0, ack asserted on the same edge as the next match → state IDLE, `cap_valid`=0, `overrun`=0.
- Assert `res` mid-count at `q`=9 with a capture pending → all outputs return to their reset values; no `match` on the first post-reset edge with `cmp`=0.
- `cmp`=15, armed → `cap_data`=0x00F before the first wrap; `wrap_cnt`=1 one cycle later.
